forward_unit: RTL and testbench
===============================

# forward_unit

Operand-forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It shadows the destination-register fields of the instructions in the EX and MEM stages. For each instruction leaving ID, it produces the registered 2-bit select codes that drive the 32-bit 4-to-1 operand selectors in front of the ALU. It also raises a one-cycle stall when an instruction needs a load result that is not yet available.

## Interface
- No parameters. Register index width is fixed at 5 bits; select width is fixed at 2 bits.
- clk  input  1  Core clock; all state updates on the rising edge.
- rst  input  1  Reset: synchronous, active-high.
- id_valid  input  1  The ID stage holds a real instruction.
- id_rs  input  5  Source A register index of the ID instruction.
- id_rt  input  5  Source B register index of the ID instruction.
- id_use_imm  input  1  Operand B of the ID instruction is the immediate.
- id_dst  input  5  Destination register index of the ID instruction.
- id_we  input  1  The ID instruction writes the register file.
- id_load  input  1  The ID instruction is a load (lw).
- hold  input  1  Global freeze from the memory system; all state holds.
- flush  input  1  Branch/jump flush; the ID instruction is discarded.
- fwd_a_sel  output  2  Operand A selector for the EX stage (registered).
- fwd_b_sel  output  2  Operand B selector for the EX stage (registered).
- ld_stall  output  1  Combinational. Freezes PC and IF/ID, and makes ID/EX a bubble.
- stall_count  output  32  Count of load-use stall cycles (only when the macro below is defined).

## Operation
- Select encoding:
  - 00 = register-file read value
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB write-back value
  - 11 = sign-extended immediate (operand B only; operand A never produces 11)
- Internal shadow state: ex_valid/ex_dst/ex_we/ex_load and mem_valid/mem_dst/mem_we. On every non-hold edge, ID advances into EX and EX advances into MEM.
- A producer "matches" a source index s when all of these hold: the producer is valid, it has we=1, its dst equals s, and s is not 0.
- Operand A, evaluated in ID:
  - 01 if the EX-stage producer matches id_rs.
  - Otherwise 10 if the MEM-stage producer matches id_rs.
  - Otherwise 00.
  - The nearer producer always wins.
- Operand B: 11 if id_use_imm. Otherwise the same rule as A, applied to id_rt.
- ld_stall = id_valid & ex_valid & ex_load & ex_we & (ex_dst != 0) & (ex_dst == id_rs | (ex_dst == id_rt & ~id_use_imm)).
- While ld_stall is asserted:
  - EX is loaded with a bubble (ex_valid = 0, fwd selects = 00).
  - The ID inputs stay stable, and the next cycle re-evaluates them.
  - On re-evaluation the load is in MEM, so the select becomes 10.
- flush: EX is loaded with a bubble and the selects are set to 00. id_valid = 0 has the same effect.
- Priority: rst > hold > (flush | ld_stall). flush and ld_stall together give one bubble. ld_stall is forced to 0 while flush is high.
- Write-back to the register file in the same cycle as the ID read is handled by the write-first register file. This block does not forward from distance 3.

## Timing
- Reset values:
  - fwd_a_sel = 00, fwd_b_sel = 00
  - ex_valid = 0, mem_valid = 0, so ld_stall = 0
  - stall_count = 0
- Latency: the selectors are registered. Values computed while the instruction is in ID appear on fwd_*_sel in the cycle that instruction occupies EX.
- ld_stall is combinational from the ID inputs and the EX shadow state, and is valid in the same cycle.
- hold = 1: every register keeps its value, fwd_*_sel stay constant, and stall_count does not increment. ld_stall still reflects its inputs, but the frozen pipeline ignores it.
- Reset mid-operation: all shadow state is invalidated on the next edge, so no forwarding from instructions issued before reset.
- A load-use stall lasts exactly one cycle per dependent instruction, with no back-to-back stall for the same pair.

## Configuration
- FWD_STALL_CNT_EN defined:
  - stall_count is present.
  - It increments by 1 on each edge where ld_stall = 1, hold = 0 and rst = 0.
  - It wraps from 0xFFFFFFFF to 0.
- FWD_STALL_CNT_EN undefined: the stall_count port and counter are absent. Forwarding and stall behaviour are identical.

## Test plan
- add $3 written, next instruction reads $3 as rs -> fwd_a_sel = 01 in that instruction's EX cycle, ld_stall = 0.
- add $3, then nop, then use $3 as rt -> fwd_b_sel = 10. With add $3 twice in a row, then use -> 01 (nearest wins).
- lw $5, then add $6,$5,$2 -> ld_stall = 1 for one cycle and EX gets a bubble (selects 00). Next cycle fwd_a_sel = 10, and stall_count goes from 0 to 1 when FWD_STALL_CNT_EN is defined.
- Writer to $0 followed by a reader of $0 -> selects 00, no stall. addi with id_use_imm = 1 -> fwd_b_sel = 11.
- lw $5 with a dependent instruction in ID, flush = 1 in the same cycle -> ld_stall = 0, EX gets a bubble. hold = 1 for 3 cycles -> selects and count unchanged.
- rst asserted while add $3 is in EX -> next cycle, a reader of $3 gets select 00 and all outputs are at their reset values.

Source files
------------

// File: rtl/forward_unit.sv
// Operand-forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Optional load-use stall counter is built when FWD_STALL_CNT_EN is defined.
module forward_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_imm,
  input  logic [4:0]  id_dst,
  input  logic        id_we,
  input  logic        id_load,
  input  logic        hold,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        ld_stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  logic       r_ex_valid;
  logic [4:0] r_ex_dst;
  logic       r_ex_we;
  logic       r_ex_load;
  logic       r_mem_valid;
  logic [4:0] r_mem_dst;
  logic       r_mem_we;
  logic [1:0] r_fwd_a_sel;
  logic [1:0] r_fwd_b_sel;

  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic       w_mem_hit_a;
  logic       w_mem_hit_b;
  logic       w_ld_stall;
  logic       w_issue;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  // A producer matches a source when it is a live register writer of a nonzero index.
  function automatic logic f_match(input logic v, input logic we,
                                   input logic [4:0] dst, input logic [4:0] src);
    return v & we & (dst == src) & (src != 5'd0);
  endfunction

  // Producer hit detection against both ID source operands.
  always_comb begin
    w_ex_hit_a  = f_match(r_ex_valid, r_ex_we, r_ex_dst, id_rs);
    w_ex_hit_b  = f_match(r_ex_valid, r_ex_we, r_ex_dst, id_rt);
    w_mem_hit_a = f_match(r_mem_valid, r_mem_we, r_mem_dst, id_rs);
    w_mem_hit_b = f_match(r_mem_valid, r_mem_we, r_mem_dst, id_rt);
  end

  // Load-use hazard: a flush already discards the consumer, so it suppresses the stall.
  always_comb begin
    w_ld_stall = ~flush & id_valid & r_ex_valid & r_ex_load & r_ex_we &
                 (r_ex_dst != 5'd0) &
                 ((r_ex_dst == id_rs) | ((r_ex_dst == id_rt) & ~id_use_imm));
    w_issue    = id_valid & ~flush & ~w_ld_stall;
  end

  // Operand A select: nearer producer wins.
  always_comb begin
    w_sel_a = SEL_RF;
    if (w_ex_hit_a) begin
      w_sel_a = SEL_EX;
    end else if (w_mem_hit_a) begin
      w_sel_a = SEL_MEM;
    end else begin
      w_sel_a = SEL_RF;
    end
  end

  // Operand B select: immediate overrides any register dependency.
  always_comb begin
    w_sel_b = SEL_RF;
    if (id_use_imm) begin
      w_sel_b = SEL_IMM;
    end else if (w_ex_hit_b) begin
      w_sel_b = SEL_EX;
    end else if (w_mem_hit_b) begin
      w_sel_b = SEL_MEM;
    end else begin
      w_sel_b = SEL_RF;
    end
  end

  // Shadow pipeline and registered selects; non-issuing cycles load a bubble into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_dst    <= 5'd0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_dst   <= 5'd0;
      r_mem_we    <= 1'b0;
      r_fwd_a_sel <= SEL_RF;
      r_fwd_b_sel <= SEL_RF;
    end else if (!hold) begin
      r_mem_valid <= r_ex_valid;
      r_mem_dst   <= r_ex_dst;
      r_mem_we    <= r_ex_we;
      r_ex_valid  <= w_issue;
      r_ex_dst    <= id_dst;
      r_ex_we     <= id_we;
      r_ex_load   <= id_load;
      r_fwd_a_sel <= w_issue ? w_sel_a : SEL_RF;
      r_fwd_b_sel <= w_issue ? w_sel_b : SEL_RF;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Stall-cycle counter, frozen by hold and wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (!hold && w_ld_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
  assign ld_stall  = w_ld_stall;

endmodule

// File: tb/tb_forward_unit.sv
// Table-driven bench for forward_unit: each row is one ID cycle; expected
// selects/count are queued at drive time and checked after the next edge.
module tb_forward_unit;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_imm, id_we, id_load, hold, flush;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        ld_stall;
  logic [31:0] stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  forward_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_imm(id_use_imm), .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
    .hold(hold), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ld_stall(ld_stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

`ifndef FWD_STALL_CNT_EN
  assign stall_count = 32'd0;
`endif

  typedef struct {
    logic        rst, hold, flush, valid;
    logic [4:0]  rs, rt;
    logic        imm;
    logic [4:0]  dst;
    logic        we, load;
    logic        e_stall;
    logic [1:0]  e_a, e_b;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[30];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic h, input logic f, input logic v,
                              input logic [4:0] rs, input logic [4:0] rt, input logic imm,
                              input logic [4:0] dst, input logic we, input logic ld,
                              input logic es, input logic [1:0] ea, input logic [1:0] eb,
                              input logic [31:0] ec);
    vec_t t;
    t.rst = r; t.hold = h; t.flush = f; t.valid = v; t.rs = rs; t.rt = rt;
    t.imm = imm; t.dst = dst; t.we = we; t.load = ld;
    t.e_stall = es; t.e_a = ea; t.e_b = eb; t.e_cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, want);
  endtask

  task automatic apply(input vec_t v, input int row);
    vec_t e;
    @(negedge clk);
    rst = v.rst; hold = v.hold; flush = v.flush; id_valid = v.valid;
    id_rs = v.rs; id_rt = v.rt; id_use_imm = v.imm; id_dst = v.dst;
    id_we = v.we; id_load = v.load;
    exp_q.push_back(v);
    #1;
    check("ld_stall", row, {31'd0, ld_stall}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      e = exp_q.pop_front();
      check("fwd_a_sel", row, {30'd0, fwd_a_sel}, {30'd0, e.e_a});
      check("fwd_b_sel", row, {30'd0, fwd_b_sel}, {30'd0, e.e_b});
`ifdef FWD_STALL_CNT_EN
      check("stall_count", row, stall_count, e.e_cnt);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_use_imm = 1'b0;
    id_we = 1'b0; id_load = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_dst = 5'd0;

    //            rst   hold  flush valid rs     rt     imm   dst    we    ld    stall a      b      cnt
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  5'd1,  1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 32'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  5'd3,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd3,  1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 32'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd2,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  5'd3,  1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 32'd0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 32'd0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd0,  1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 32'd0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd2,  1'b0, 5'd6,  1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'd1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd2,  1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  5'd0,  1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 32'd1);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  5'd5,  1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd1);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd1,  1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd1);
    tbl[17] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd1);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd1);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd1);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 32'd1);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 32'd1);
    tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 5'd1,  1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 32'd1);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 5'd1,  1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 32'd2);
    tbl[24] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 5'd1,  1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'd2);
    tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 5'd16, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 32'd2);
    tbl[26] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  5'd16, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 32'd2);
    tbl[27] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd2);
    tbl[28] = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  1'b0, 5'd18, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
    tbl[29] = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  1'b0, 5'd19, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);

    for (int i = 0; i < 30; i++) apply(tbl[i], i);

    // Flushed consumer of a fresh writer becomes a bubble; the following reader sees it from MEM.
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0), 30);
    apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 5'd20, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0), 31);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 5'd20, 1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 32'd0), 32);

    // Load followed by a flushed cycle and then a dependent: dependent is two behind, no stall.
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd23, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0), 33);
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd23, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0), 34);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd23, 1'b0, 5'd24, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 32'd0), 35);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
